// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals for the
// shared-multiplier arbiter. "slave" is the arbiter's view, "master" the
// view of the environment (requesters, response sink and multiplier).
interface mul_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_p;
    logic              rsp_err;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_start;
    logic [2*W-1:0]    mul_p;
    logic              mul_done;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_p, mul_done,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_a, mul_b, mul_start
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_p, mul_done,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one sequential multiplier between NREQ requesters.
// One operation in flight at a time: IDLE grants, ISSUE pulses start,
// WAIT collects the product (or times out), RESP holds the tagged result.
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   resetn,
    mul_share_arbiter_if.slave     bus,
    output logic                   busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_d;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic            mul_start_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [2*W-1:0]  rsp_p_q;
    logic            rsp_err_q;
    logic            busy_q;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] ready_vec;

    assign cnt_d = cnt_q + 8'd1;

    // Pick the first pending requester after the last one served, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot accept strobe, only offered while idle and out of reset.
    always_comb begin
        ready_vec = '0;
        if (resetn && state_q == IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        mul_a_q     <= bus.req_a[grant_idx*W +: W];
                        mul_b_q     <= bus.req_b[grant_idx*W +: W];
                        rsp_id_q    <= grant_idx;
                        rr_ptr_q    <= grant_idx;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mul_done is deliberately not looked at here
                    mul_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    // a completion on the final allowed cycle still counts
                    if (bus.mul_done) begin
                        rsp_p_q     <= bus.mul_p;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (cnt_d == 8'(TIMEOUT)) begin
                        rsp_p_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_start = mul_start_q;
    assign busy          = busy_q;
endmodule
